// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and constants for the subtractive GCD engine.
// Holds the controller FSM state enum, the A-register input select and the
// default operand width.
package gcd_pkg;

  localparam int GCD_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPUTE,
    DONE
  } state_t;

  // Source for the A register when its load enable is asserted.
  typedef enum logic [1:0] {
    A_SEL_DIN, // operand bus
    A_SEL_SUB, // subtractor result
    A_SEL_OR   // A|B, used only by the zero guard
  } a_sel_t;

endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath: A/B operand registers, input muxes, one shared subtractor
// and the magnitude comparator.
// Ports: clk, rst (async active-high); data_in operand bus; lda/ldb load
// enables; a_sel/b_sel input selects; a_out = A register; lt/gt/eq compare
// A against B; zero (GCD_ZERO_GUARD_EN builds only) flags A==0 or B==0.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             lda,
  input  logic             ldb,
  input  a_sel_t           a_sel,
  input  logic             b_sel,
  output logic [WIDTH-1:0] a_out,
  output logic             lt,
  output logic             gt,
  output logic             eq
`ifdef GCD_ZERO_GUARD_EN
  ,
  output logic             zero
`endif
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;

  assign lt = (a_reg < b_reg);
  assign gt = (a_reg > b_reg);
  assign eq = (a_reg == b_reg);

`ifdef GCD_ZERO_GUARD_EN
  assign zero = (a_reg == '0) || (b_reg == '0);
`endif

  // Always subtract the smaller operand from the larger so the unsigned
  // difference never wraps; one subtractor serves both registers.
  assign minuend    = gt ? a_reg : b_reg;
  assign subtrahend = gt ? b_reg : a_reg;
  assign diff       = minuend - subtrahend;

  always_comb begin
    a_next = data_in;
    case (a_sel)
      A_SEL_SUB: a_next = diff;
      A_SEL_OR:  a_next = a_reg | b_reg;
      default:   a_next = data_in;
    endcase
  end

  assign b_next = b_sel ? diff : data_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (lda) a_reg <= a_next;
      if (ldb) b_reg <= b_next;
    end
  end

  assign a_out = a_reg;

endmodule

// File: rtl/gcd_controller.sv
// gcd_controller: top of the subtractive GCD engine; FSM plus datapath.
// Ports: clk, rst (async active-high); start level request; data_in carries
// A then B on consecutive cycles; done high in DONE; a_out = A register.
// Optional macro GCD_ZERO_GUARD_EN: a zero operand finishes as A|B.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic [WIDTH-1:0] a_out
);

  state_t state;
  state_t state_next;
  logic   lda;
  logic   ldb;
  a_sel_t a_sel;
  logic   b_sel;
  logic   lt;
  logic   gt;
  logic   eq;
`ifdef GCD_ZERO_GUARD_EN
  logic   zero;
`endif

  gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .lda     (lda),
    .ldb     (ldb),
    .a_sel   (a_sel),
    .b_sel   (b_sel),
    .a_out   (a_out),
    .lt      (lt),
    .gt      (gt),
    .eq      (eq)
`ifdef GCD_ZERO_GUARD_EN
    ,
    .zero    (zero)
`endif
  );

  // Control decode from current state and comparator flags.
  always_comb begin
    state_next = state;
    lda        = 1'b0;
    ldb        = 1'b0;
    a_sel      = A_SEL_DIN;
    b_sel      = 1'b0;
    case (state)
      IDLE:    if (start) state_next = LOAD_A;
      LOAD_A: begin
        lda        = 1'b1;
        state_next = LOAD_B;
      end
      LOAD_B: begin
        ldb        = 1'b1;
        state_next = COMPUTE;
      end
      COMPUTE: begin
`ifdef GCD_ZERO_GUARD_EN
        // A zero operand would never converge by subtraction; the
        // nonzero operand (or 0 for 0,0) is the answer.
        if (zero) begin
          lda        = 1'b1;
          a_sel      = A_SEL_OR;
          state_next = DONE;
        end else
`endif
        if (gt) begin
          lda   = 1'b1;
          a_sel = A_SEL_SUB;
        end else if (lt) begin
          ldb   = 1'b1;
          b_sel = 1'b1;
        end else begin
          state_next = DONE;
        end
      end
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done is registered alongside the state so it is a clean Moore output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_gcd_controller.sv
module tb_gcd_controller;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             done;
  logic [WIDTH-1:0] a_out;

  int errors = 0;
  int checks = 0;

  gcd_controller #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .done    (done),
    .a_out   (a_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: Euclid by division. The number of subtraction steps equals the
  // sum of the quotients, less one because the last quotient leaves A==B.
  function automatic void ref_gcd(input longint a, input longint b,
                                  output longint g, output longint k);
    longint x, y, r;
    if (a == 0 || b == 0) begin
      g = a | b;
      k = 0;
    end else begin
      x = a; y = b; k = 0;
      while (y != 0) begin
        k += x / y;
        r = x % y;
        x = y;
        y = r;
      end
      g = x;
      k -= 1;
    end
  endfunction

  // Drives start and the two operands; returns at the negedge after the
  // LOAD_B edge (FSM now in COMPUTE).
  task automatic load_ops(input int a, input int b, input bit wiggle);
    @(negedge clk); start = 1'b1;
    @(negedge clk); data_in = WIDTH'(a); if (wiggle) start = 1'b0;
    @(negedge clk); data_in = WIDTH'(b);
    check("load_a", a_out, a);
    @(negedge clk); data_in = WIDTH'($urandom); start = wiggle ? 1'b1 : start;
    start = 1'b1;
  endtask

  task automatic run_gcd(input string tag, input int a, input int b, input bit wiggle);
    longint g, k;
    int cycles;
    ref_gcd(a, b, g, k);
    load_ops(a, b, wiggle);
    cycles = 0;
    while (!done && cycles < k + 20) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_latency"}, cycles, k + 1);
    check({tag, "_gcd"}, a_out, g);
    check({tag, "_done"}, done, 1);
    repeat (2) @(negedge clk);
    check({tag, "_hold_done"}, done, 1);
    check({tag, "_hold_a"}, a_out, g);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_idle_done"}, done, 0);
  endtask

  initial begin
    int saw_done;
    rst = 1'b1; start = 1'b0; data_in = '0;
    #1;
    check("reset_done", done, 0);
    check("reset_a", a_out, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_start", done, 0);

    run_gcd("r143_78", 143, 78, 1'b0);
    run_gcd("r13_13", 13, 13, 1'b0);
    run_gcd("r48_18", 48, 18, 1'b0);
    run_gcd("r7_5", 7, 5, 1'b1);
    run_gcd("r0_0", 0, 0, 1'b0);

    // Asynchronous reset in the middle of COMPUTE.
    load_ops(143, 78, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_a", a_out, 52);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_done", done, 0);
    check("arst_a", a_out, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_arst_idle", done, 0);
    check("post_arst_a", a_out, 0);
    run_gcd("fresh_48_18", 48, 18, 1'b0);

`ifdef GCD_ZERO_GUARD_EN
    run_gcd("zg_0_7", 0, 7, 1'b0);
    run_gcd("zg_9_0", 9, 0, 1'b0);
`else
    // Without the guard a single zero operand never converges.
    load_ops(0, 7, 1'b0);
    saw_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    check("nz_stuck_done", saw_done, 0);
    check("nz_stuck_a", a_out, 0);
    start = 1'b0;
    rst = 1'b1; #1;
    check("nz_reset_done", done, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
`endif

    for (int i = 0; i < 8; i++) begin
      run_gcd("rand", $urandom_range(1, 1000), $urandom_range(1, 1000), i[0]);
    end

    run_gcd("max_1", 65535, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand/result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: level request that begins an operand-load sequence.
REQ-005 SHALL have port data_in, input, WIDTH bits: operand bus, first A then B on consecutive cycles.
REQ-006 SHALL have port done, output, 1 bit: high while the result is valid.
REQ-007 SHALL have port a_out, output, WIDTH bits: the A register, which holds the GCD once done=1.

Function
REQ-008 FSM states SHALL be: IDLE, LOAD_A, LOAD_B, COMPUTE, DONE.
REQ-009 IDLE SHALL go to LOAD_A on a clock edge with start=1, and otherwise stay in IDLE.
REQ-010 LOAD_A SHALL capture data_in into A on the next edge and go to LOAD_B, regardless of start.
REQ-011 LOAD_B SHALL capture data_in into B on the next edge and go to COMPUTE.
REQ-012 COMPUTE SHALL do one step per clock, with the comparator acting on the current A and B:
- A>B: A <= A-B
- A<B: B <= B-A
- A==B: no register change, go to DONE
REQ-013 Subtraction SHALL be unsigned and WIDTH bits wide; it cannot underflow because the smaller operand is always the one subtracted.
REQ-014 DONE SHALL drive done=1 as a Moore output; A and B SHALL hold.
REQ-015 DONE SHALL stay in DONE while start=1 and SHALL go to IDLE on an edge with start=0.
REQ-016 A new start SHALL therefore need start low for at least one edge after DONE.
REQ-017 done SHALL be 0 in every state other than DONE.
REQ-018 a_out SHALL always equal the A register, including during COMPUTE.
REQ-019 Latency: with k subtraction steps, DONE SHALL be entered k+1 edges after the LOAD_B edge.
REQ-020 start SHALL be ignored in LOAD_A, LOAD_B and COMPUTE.

Reset
REQ-021 rst=1 SHALL immediately (asynchronously) force the state to IDLE, A=0, B=0 and done=0, including mid-COMPUTE.
REQ-022 After rst deasserts, the first start SHALL begin a fresh load sequence.

Configuration
REQ-023 Macro GCD_ZERO_GUARD_EN defined: on entry to COMPUTE, or during COMPUTE, if A==0 or B==0 the block SHALL set A <= A|B in one cycle and then go to DONE. For 0,0 the result SHALL be 0.
REQ-024 Macro GCD_ZERO_GUARD_EN undefined: no zero check. With a zero operand and a nonzero operand the FSM SHALL remain in COMPUTE until reset; 0,0 SHALL reach DONE via the equal path.

Structure
REQ-025 Shared package gcd_pkg SHALL hold the FSM state enum and the default WIDTH constant.
REQ-026 Datapath SHALL be sub-module gcd_datapath, containing:
- A and B registers with load enables
- data_in / subtractor input muxes
- the single subtractor
- the lt/gt/eq comparator
REQ-027 gcd_controller SHALL hold the FSM and drive lda, ldb, the mux selects and done from state plus lt/gt/eq.

Verification
REQ-028 start=1 before edge 0; data_in=143 at edge 1, 78 at edge 2 -> B loaded at edge 2, six subtractions, DONE at edge 9, a_out=13, done=1 held while start=1.
REQ-029 Operands 13,13 -> DONE one edge after the LOAD_B edge, a_out=13.
REQ-030 Operands 48,18 -> a_out=6, done=1; then start=0 -> IDLE, done=0; restart with 7,5 -> a_out=1.
REQ-031 rst pulsed mid-COMPUTE (143,78 run) -> done=0, a_out=0 and state IDLE immediately, without waiting for a clock edge.
REQ-032 With GCD_ZERO_GUARD_EN: operands 0,7 -> a_out=7, done=1; operands 0,0 -> a_out=0, done=1.
REQ-033 Operands 65535,1 with WIDTH=16 -> a_out=1 after 65534 subtraction steps, with no wrap-around.
